// File: rtl/pio_access_arbiter.sv
// pio_access_arbiter: round-robin sharing of one Avalon-MM PIO slave among NUM_REQ requesters.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   req_valid/req_write : per-requester request valid and access type (1 = write)
//   req_address/_wdata  : packed per-requester address and write data
//   req_ready           : one-hot accept strobe, combinational, only in IDLE
//   rsp_valid           : one-hot single-cycle completion pulse
//   rsp_readdata        : data of the most recent completed read
//   m_*                 : PIO master side, one chipselect cycle per transaction
//   busy                : high whenever a transaction is in flight
module pio_access_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_readdata,
   output logic [ADDR_W-1:0]         m_address,
   output logic                      m_chipselect,
   output logic                      m_write_n,
   output logic [DATA_W-1:0]         m_writedata,
   input  logic [DATA_W-1:0]         m_readdata,
   output logic                      busy
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t        state;
   logic [IW-1:0] last_grant, cur, gnt;
   // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      gnt = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (req_valid[(int'(last_grant) + k) % NUM_REQ]) gnt = IW'((int'(last_grant) + k) % NUM_REQ);
   end
   assign req_ready = (reset_n && state == IDLE && |req_valid) ? ONE << gnt : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= IDLE;
         last_grant   <= IW'(NUM_REQ - 1);
         cur          <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_address    <= '0;
         m_writedata  <= '0;
         rsp_valid    <= '0;
         rsp_readdata <= '0;
      end else
         case (state)
            IDLE:
               if (|req_valid) begin
                  cur          <= gnt;
                  m_chipselect <= 1'b1;
                  m_write_n    <= ~req_write[gnt];
                  m_address    <= req_address[int'(gnt)*ADDR_W +: ADDR_W];
                  m_writedata  <= req_writedata[int'(gnt)*DATA_W +: DATA_W];
                  state        <= ACCESS;
               end
            ACCESS: begin
               // m_write_n still reflects the access in flight, so it selects read capture.
               if (m_write_n) rsp_readdata <= m_readdata;
               m_chipselect <= 1'b0;
               m_write_n    <= 1'b1;
               rsp_valid    <= ONE << cur;
               state        <= DONE;
            end
            DONE: begin
               rsp_valid  <= '0;
               last_grant <= cur;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_pio_access_arbiter.sv
// tb_pio_access_arbiter: directed scoreboard bench for pio_access_arbiter with a PIO register model.
module tb_pio_access_arbiter;
   localparam int N = 4, AW = 2, DW = 32;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0] req_valid = '0, req_write = '0;
   logic [N*AW-1:0] req_address = '0;
   logic [N*DW-1:0] req_writedata = '0;
   logic [N-1:0] req_ready, rsp_valid;
   logic [DW-1:0] rsp_readdata, m_writedata, m_readdata;
   logic [AW-1:0] m_address;
   logic m_chipselect, m_write_n, busy;
   logic [DW-1:0] mem [4];
   typedef struct {int idx; logic [DW-1:0] rd;} exp_t;
   exp_t q[$];
   logic [DW-1:0] exp_mem [4];
   logic [DW-1:0] exp_last_rd = '0;
   int n_checks = 0, n_fail = 0, cyc = 0, cs_count = 0;

   always #5 clk = ~clk;

   pio_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
      .req_address(req_address), .req_writedata(req_writedata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .m_address(m_address),
      .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .busy(busy));

   assign m_readdata = mem[m_address];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_chipselect && !m_write_n) mem[m_address] <= m_writedata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (m_chipselect) cs_count++;
      if (reset_n && rsp_valid != '0) begin
         if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
         else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
            chk("rsp_readdata", rsp_readdata, e.rd);
         end
      end
   end

   task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
      exp_t e;
      req_write[i] = w;
      req_address[i*AW +: AW] = a;
      req_writedata[i*DW +: DW] = d;
      req_valid[i] = 1'b1;
      waited = 0;
      #1;
      while (!req_ready[i] && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("req_ready", 32'(req_ready), 32'(1 << i));
      e.idx = i;
      if (w) begin
         exp_mem[a] = d;
         e.rd = exp_last_rd;
      end else begin
         exp_last_rd = exp_mem[a];
         e.rd = exp_last_rd;
      end
      q.push_back(e);
      @(negedge clk);
      req_valid[i] = 1'b0;
      chk("access_cs", 32'(m_chipselect), 32'h1);
      chk("access_write_n", 32'(m_write_n), 32'(!w));
      chk("access_address", 32'(m_address), 32'(a));
      if (w) chk("access_writedata", m_writedata, d);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      #2;
      while ((busy || q.size() != 0) && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("idle_timeout", 32'(n < 20), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, k, last, n, c0;
      exp_t e;
      for (int i = 0; i < 4; i++) exp_mem[i] = '0;
      repeat (3) @(negedge clk);
      req_valid = '1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_cs", 32'(m_chipselect), 32'h0);
      chk("rst_write_n", 32'(m_write_n), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_readdata", rsp_readdata, 32'h0);
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(0, 1'b1, 2'd0, 32'hDEADBEEF, w);
      chk("first_accept_wait", 32'(w), 32'h0);
      wait_idle();
      chk("pio_mem0", mem[0], 32'hDEADBEEF);
      issue(2, 1'b0, 2'd0, 32'h0, w);
      wait_idle();
      issue(3, 1'b1, 2'd3, 32'h33333333, w);
      wait_idle();
      // round robin: all four requesters write their index to their index
      req_write = '1;
      for (int i = 0; i < N; i++) begin
         req_address[i*AW +: AW] = AW'(i);
         req_writedata[i*DW +: DW] = DW'(i);
      end
      k = 0;
      last = 0;
      n = 0;
      req_valid = '1;
      #1;
      while (k < 8 && n < 60) begin
         if (req_ready != '0) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            e.idx = k % 4;
            e.rd = exp_last_rd;
            exp_mem[k % 4] = DW'(k % 4);
            q.push_back(e);
            k++;
         end
         @(negedge clk);
         #1;
         n++;
      end
      req_valid = '0;
      chk("rr_count", 32'(k), 32'd8);
      wait_idle();
      chk("pio_mem2_rr", mem[2], 32'd2);
      // wrap and skip: last grant was 3, only requester 2 requests
      issue(2, 1'b1, 2'd1, 32'hA5A5A5A5, w);
      chk("wrap_no_idle_cycle", 32'(w), 32'h0);
      wait_idle();
      // withdrawn request during ACCESS
      c0 = cs_count;
      issue(0, 1'b1, 2'd2, 32'h12345678, w);
      req_valid[1] = 1'b1;
      req_write[1] = 1'b0;
      #1;
      chk("withdraw_ready_access", 32'(req_ready), 32'h0);
      @(negedge clk);
      req_valid[1] = 1'b0;
      #1;
      chk("withdraw_ready_done", 32'(req_ready), 32'h0);
      wait_idle();
      chk("withdraw_cs_count", 32'(cs_count - c0), 32'h1);
      // reset asserted during the ACCESS cycle of a read
      issue(3, 1'b0, 2'd1, 32'h0, w);
      reset_n = 1'b0;
      q.delete();
      exp_last_rd = '0;
      req_valid = '1;
      #1;
      chk("mid_rst_cs", 32'(m_chipselect), 32'h0);
      chk("mid_rst_write_n", 32'(m_write_n), 32'h1);
      chk("mid_rst_address", 32'(m_address), 32'h0);
      chk("mid_rst_writedata", m_writedata, 32'h0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_rst_readdata", rsp_readdata, 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      c0 = cs_count;
      repeat (5) @(negedge clk);
      #1;
      chk("post_rst_no_cs", 32'(cs_count - c0), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
      req_write[0] = 1'b1;
      req_address[0 +: AW] = 2'd0;
      req_writedata[0 +: DW] = 32'h00C0FFEE;
      req_valid = '1;
      #1;
      chk("post_rst_priority", 32'(req_ready), 32'h1);
      e.idx = 0;
      e.rd = exp_last_rd;
      q.push_back(e);
      @(negedge clk);
      req_valid = '0;
      wait_idle();
      chk("pio_mem0_post_rst", mem[0], 32'h00C0FFEE);
      chk("scoreboard_empty", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
